// File: rtl/locked_register_bank_if.sv
// Bus interface for locked_register_bank.
// Groups the write, read, lock and unlock-sequence signals of the bank.
//   master : drives requests (config bus side) and observes results.
//   slave  : the register bank itself.
// Signals:
//   write/waddr/Data_in        write strobe, index and data
//   lock_set                   per-register lock request (level)
//   scan_mode, debug_unlocked  security qualifiers
//   unlock_req/idx/key         unlock key strobe, target index, key value
//   raddr/Data_out             read index, registered read data
//   lock_status                current lock bits
//   write_err/unlock_done/unlock_err  single-cycle status pulses
interface locked_register_bank_if #(
  parameter int N_REGS = 4,
  parameter int WIDTH  = 16
);
  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic              write;
  logic [AW-1:0]     waddr;
  logic [WIDTH-1:0]  Data_in;
  logic [N_REGS-1:0] lock_set;
  logic              scan_mode;
  logic              debug_unlocked;
  logic              unlock_req;
  logic [AW-1:0]     unlock_idx;
  logic [WIDTH-1:0]  unlock_key;
  logic [AW-1:0]     raddr;
  logic [WIDTH-1:0]  Data_out;
  logic [N_REGS-1:0] lock_status;
  logic              write_err;
  logic              unlock_done;
  logic              unlock_err;

  modport master (
    output write, waddr, Data_in, lock_set, scan_mode, debug_unlocked,
           unlock_req, unlock_idx, unlock_key, raddr,
    input  Data_out, lock_status, write_err, unlock_done, unlock_err
  );

  modport slave (
    input  write, waddr, Data_in, lock_set, scan_mode, debug_unlocked,
           unlock_req, unlock_idx, unlock_key, raddr,
    output Data_out, lock_status, write_err, unlock_done, unlock_err
  );
endinterface

// File: rtl/locked_register_bank.sv
// Bank of N_REGS data registers, each guarded by a sticky lock bit.
// A locked register refuses writes until reset, or until a two-key unlock
// sequence (KEY0 then KEY1 on the same index within TIMEOUT cycles) completes
// while debug_unlocked is high. scan_mode refuses all writes and unlocks but
// never sets or clears a lock by itself.
// Ports:
//   Clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : locked_register_bank_if.slave (write/read/lock/unlock signals)
module locked_register_bank #(
  parameter int               N_REGS    = 4,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] KEY0      = 16'hA5A5,
  parameter logic [WIDTH-1:0] KEY1      = 16'h5A5A,
  parameter int               TIMEOUT   = 16
) (
  input  logic                  Clk,
  input  logic                  reset,
  locked_register_bank_if.slave bus
);
  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   NREG_LIM  = (AW + 1)'(N_REGS);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic {IDLE, ARMED} state_t;

  logic [WIDTH-1:0]  regs_q [N_REGS];
  logic [N_REGS-1:0] lock_q;
  logic [WIDTH-1:0]  rd_data_p1;
  logic              write_err_p1;
  logic              unlock_done_p1;
  logic              unlock_err_p1;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              done_d, err_d;
  logic [N_REGS-1:0] clr_mask;

  logic waddr_ok, raddr_ok, uidx_ok, wr_accept_p0;

  // Stage p0: request qualification
  assign waddr_ok = {1'b0, bus.waddr}      < NREG_LIM;
  assign raddr_ok = {1'b0, bus.raddr}      < NREG_LIM;
  assign uidx_ok  = {1'b0, bus.unlock_idx} < NREG_LIM;

  // A lock request to the written register in the same cycle blocks the write.
  assign wr_accept_p0 = bus.write && waddr_ok && !bus.scan_mode &&
                        !lock_q[bus.waddr] && !bus.lock_set[bus.waddr];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (bus.unlock_req) begin
          if (bus.unlock_key == KEY0 && bus.debug_unlocked && !bus.scan_mode && uidx_ok) begin
            state_d = ARMED;
            timer_d = TIMEOUT_V;
            idx_d   = bus.unlock_idx;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARMED: begin
        timer_d = timer_q - TIMER_ONE;
        // Losing authorisation aborts first; a key strobe is honoured even on
        // the last cycle of the window, so KEY1 may arrive up to TIMEOUT cycles
        // after KEY0.
        if (!bus.debug_unlocked || bus.scan_mode) begin
          state_d = IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end else if (bus.unlock_req) begin
          state_d = IDLE;
          timer_d = '0;
          if (bus.unlock_key == KEY1 && bus.unlock_idx == idx_q) begin
            done_d          = 1'b1;
            clr_mask[idx_q] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_q <= TIMER_ONE) begin
          state_d = IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered state, data and pulses
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      lock_q         <= '0;
      write_err_p1   <= 1'b0;
      unlock_done_p1 <= 1'b0;
      unlock_err_p1  <= 1'b0;
    end else begin
      // Set requests are applied after the clear so a simultaneous lock wins.
      lock_q         <= (lock_q & ~clr_mask) | bus.lock_set;
      write_err_p1   <= bus.write && !wr_accept_p0;
      unlock_done_p1 <= done_d;
      unlock_err_p1  <= err_d;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL;
      rd_data_p1 <= RESET_VAL;
    end else begin
      if (wr_accept_p0) regs_q[bus.waddr] <= bus.Data_in;
      rd_data_p1 <= raddr_ok ? regs_q[bus.raddr] : '0;
    end
  end

  assign bus.Data_out    = rd_data_p1;
  assign bus.lock_status = lock_q;
  assign bus.write_err   = write_err_p1;
  assign bus.unlock_done = unlock_done_p1;
  assign bus.unlock_err  = unlock_err_p1;
endmodule

// File: tb/tb_locked_register_bank.sv
module tb_locked_register_bank;
  localparam int N_REGS  = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 16;
  localparam logic [15:0] KEY0 = 16'hA5A5;
  localparam logic [15:0] KEY1 = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  locked_register_bank_if #(.N_REGS(N_REGS), .WIDTH(WIDTH)) bus ();

  locked_register_bank #(
    .N_REGS(N_REGS), .WIDTH(WIDTH), .RESET_VAL(16'h0000),
    .KEY0(KEY0), .KEY1(KEY1), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write = 1'b0; bus.waddr = '0; bus.Data_in = '0; bus.lock_set = '0;
    bus.scan_mode = 1'b0; bus.unlock_req = 1'b0; bus.unlock_idx = '0;
    bus.unlock_key = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.debug_unlocked = 1'b0;
    bus.raddr = 2'd0;
    tick(); tick();
    checks++; if (bus.Data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=%h", bus.Data_out, 16'h0000); end
    checks++; if (bus.lock_status !== 4'b0000) begin failures++; $display("FAIL reset_lock got=%b exp=%b", bus.lock_status, 4'b0000); end
    checks++; if ({bus.write_err, bus.unlock_done, bus.unlock_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=%b", {bus.write_err, bus.unlock_done, bus.unlock_err}, 3'b000); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    bus.write = 1'b1; bus.waddr = 2'd2; bus.Data_in = 16'h1234; bus.raddr = 2'd2;
    tick();
    checks++; if (bus.Data_out !== 16'h0000) begin failures++; $display("FAIL same_cycle_read got=%h exp=%h", bus.Data_out, 16'h0000); end
    checks++; if (bus.write_err !== 1'b0) begin failures++; $display("FAIL write_ok_err got=%b exp=%b", bus.write_err, 1'b0); end
    bus.write = 1'b0;
    tick();
    checks++; if (bus.Data_out !== 16'h1234) begin failures++; $display("FAIL read_reg2 got=%h exp=%h", bus.Data_out, 16'h1234); end
  endtask

  task automatic test_lock();
    bus.lock_set = 4'b0100;
    tick();
    bus.lock_set = 4'b0000;
    checks++; if (bus.lock_status !== 4'b0100) begin failures++; $display("FAIL lock_set2 got=%b exp=%b", bus.lock_status, 4'b0100); end
    bus.write = 1'b1; bus.waddr = 2'd2; bus.Data_in = 16'hFFFF;
    tick();
    bus.write = 1'b0;
    checks++; if (bus.write_err !== 1'b1) begin failures++; $display("FAIL locked_write_err got=%b exp=%b", bus.write_err, 1'b1); end
    tick();
    checks++; if (bus.write_err !== 1'b0) begin failures++; $display("FAIL write_err_pulse got=%b exp=%b", bus.write_err, 1'b0); end
    checks++; if (bus.Data_out !== 16'h1234) begin failures++; $display("FAIL locked_reg2_kept got=%h exp=%h", bus.Data_out, 16'h1234); end
    // Lock and write to reg1 in the same cycle: the lock wins.
    bus.lock_set = 4'b0010; bus.write = 1'b1; bus.waddr = 2'd1; bus.Data_in = 16'hBEEF; bus.raddr = 2'd1;
    tick();
    bus.lock_set = 4'b0000; bus.write = 1'b0;
    checks++; if (bus.write_err !== 1'b1) begin failures++; $display("FAIL same_cycle_lock_err got=%b exp=%b", bus.write_err, 1'b1); end
    checks++; if (bus.lock_status !== 4'b0110) begin failures++; $display("FAIL same_cycle_lock got=%b exp=%b", bus.lock_status, 4'b0110); end
    tick();
    checks++; if (bus.Data_out !== 16'h0000) begin failures++; $display("FAIL reg1_unwritten got=%h exp=%h", bus.Data_out, 16'h0000); end
  endtask

  task automatic test_scan();
    bus.scan_mode = 1'b1; bus.write = 1'b1; bus.waddr = 2'd0; bus.Data_in = 16'h1111; bus.raddr = 2'd0;
    tick();
    bus.write = 1'b0;
    checks++; if (bus.write_err !== 1'b1) begin failures++; $display("FAIL scan_write_err got=%b exp=%b", bus.write_err, 1'b1); end
    checks++; if (bus.lock_status !== 4'b0110) begin failures++; $display("FAIL scan_lock_kept got=%b exp=%b", bus.lock_status, 4'b0110); end
    bus.scan_mode = 1'b0;
    tick();
    checks++; if (bus.lock_status !== 4'b0110) begin failures++; $display("FAIL scan_off_lock got=%b exp=%b", bus.lock_status, 4'b0110); end
    checks++; if (bus.Data_out !== 16'h0000) begin failures++; $display("FAIL scan_reg0_kept got=%h exp=%h", bus.Data_out, 16'h0000); end
  endtask

  task automatic test_unlock_ok();
    bus.debug_unlocked = 1'b1;
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0;
    checks++; if (bus.unlock_err !== 1'b0) begin failures++; $display("FAIL key0_no_err got=%b exp=%b", bus.unlock_err, 1'b0); end
    tick(); tick();
    bus.unlock_req = 1'b1; bus.unlock_key = KEY1; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0;
    checks++; if (bus.unlock_done !== 1'b1) begin failures++; $display("FAIL unlock_done got=%b exp=%b", bus.unlock_done, 1'b1); end
    checks++; if (bus.lock_status !== 4'b0010) begin failures++; $display("FAIL unlock_cleared got=%b exp=%b", bus.lock_status, 4'b0010); end
    bus.write = 1'b1; bus.waddr = 2'd2; bus.Data_in = 16'hABCD; bus.raddr = 2'd2;
    tick();
    bus.write = 1'b0;
    checks++; if (bus.unlock_done !== 1'b0) begin failures++; $display("FAIL unlock_done_pulse got=%b exp=%b", bus.unlock_done, 1'b0); end
    checks++; if (bus.write_err !== 1'b0) begin failures++; $display("FAIL unlocked_write_err got=%b exp=%b", bus.write_err, 1'b0); end
    tick();
    checks++; if (bus.Data_out !== 16'hABCD) begin failures++; $display("FAIL unlocked_write_data got=%h exp=%h", bus.Data_out, 16'hABCD); end
  endtask

  task automatic test_unlock_err();
    int early_err;
    bus.lock_set = 4'b0100;
    tick();
    bus.lock_set = 4'b0000;
    // Timeout: KEY1 presented TIMEOUT+1 cycles after KEY0.
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0;
    early_err = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k < TIMEOUT && bus.unlock_err) early_err++;
    end
    checks++; if (early_err !== 0) begin failures++; $display("FAIL timeout_early_err got=%0d exp=%0d", early_err, 0); end
    checks++; if (bus.unlock_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=%b", bus.unlock_err, 1'b1); end
    bus.unlock_req = 1'b1; bus.unlock_key = KEY1; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0;
    checks++; if ({bus.unlock_done, bus.unlock_err} !== 2'b01) begin failures++; $display("FAIL late_key1 got=%b exp=%b", {bus.unlock_done, bus.unlock_err}, 2'b01); end
    checks++; if (bus.lock_status !== 4'b0110) begin failures++; $display("FAIL timeout_lock_kept got=%b exp=%b", bus.lock_status, 4'b0110); end
    // Wrong second key.
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_key = 16'h1234;
    tick();
    bus.unlock_req = 1'b0;
    checks++; if ({bus.unlock_done, bus.unlock_err} !== 2'b01) begin failures++; $display("FAIL wrong_key got=%b exp=%b", {bus.unlock_done, bus.unlock_err}, 2'b01); end
    // KEY1 on a different index.
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_key = KEY1; bus.unlock_idx = 2'd1;
    tick();
    bus.unlock_req = 1'b0;
    checks++; if ({bus.unlock_done, bus.unlock_err} !== 2'b01) begin failures++; $display("FAIL wrong_idx got=%b exp=%b", {bus.unlock_done, bus.unlock_err}, 2'b01); end
    checks++; if (bus.lock_status !== 4'b0110) begin failures++; $display("FAIL err_lock_kept got=%b exp=%b", bus.lock_status, 4'b0110); end
    // Dropping debug authorisation while armed aborts at once.
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0; bus.debug_unlocked = 1'b0;
    tick();
    bus.debug_unlocked = 1'b1;
    checks++; if (bus.unlock_err !== 1'b1) begin failures++; $display("FAIL debug_drop_err got=%b exp=%b", bus.unlock_err, 1'b1); end
    // Lock request in the same cycle as the clear: lock stays, done still pulses.
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_key = KEY1; bus.lock_set = 4'b0100;
    tick();
    bus.unlock_req = 1'b0; bus.lock_set = 4'b0000;
    checks++; if (bus.unlock_done !== 1'b1) begin failures++; $display("FAIL lock_wins_done got=%b exp=%b", bus.unlock_done, 1'b1); end
    checks++; if (bus.lock_status !== 4'b0110) begin failures++; $display("FAIL lock_wins_status got=%b exp=%b", bus.lock_status, 4'b0110); end
  endtask

  task automatic test_reset_mid_sequence();
    bus.unlock_req = 1'b1; bus.unlock_key = KEY0; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({bus.unlock_done, bus.unlock_err, bus.write_err} !== 3'b000) begin failures++; $display("FAIL mid_reset_pulses got=%b exp=%b", {bus.unlock_done, bus.unlock_err, bus.write_err}, 3'b000); end
    checks++; if (bus.lock_status !== 4'b0000) begin failures++; $display("FAIL mid_reset_lock got=%b exp=%b", bus.lock_status, 4'b0000); end
    tick();
    rst = 1'b0;
    tick();
    bus.unlock_req = 1'b1; bus.unlock_key = KEY1; bus.unlock_idx = 2'd2;
    tick();
    bus.unlock_req = 1'b0;
    checks++; if ({bus.unlock_done, bus.unlock_err} !== 2'b01) begin failures++; $display("FAIL lone_key1 got=%b exp=%b", {bus.unlock_done, bus.unlock_err}, 2'b01); end
    for (int i = 0; i < N_REGS; i++) begin
      bus.raddr = 2'(i);
      tick();
      checks++; if (bus.Data_out !== 16'h0000) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, bus.Data_out, 16'h0000); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_lock();
    test_scan();
    test_unlock_ok();
    test_unlock_err();
    test_reset_mid_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
